alu_ctrl_mdu: RTL and testbench
===============================

# alu_ctrl_mdu

- Parametrised successor to the single-cycle ALU control decoder.
- Decodes `ALUOp`/`funct3`/`funct7` into the extended ALU control code for the full RV32I/RV64I arithmetic set, including I-type arithmetic.
- Adds an iterative multiply/divide unit for the RISC-V M extension, which stalls the core while it runs.
- Sits between the main control unit/register file and the ALU; its `stall` output holds the PC and pipeline registers.

## Interface
- `XLEN`, default 32: operand/result width; legal values 32 and 64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `ALUOp`  in  2  from main control:
  - 00 = ADD (load/store)
  - 01 = SUB (branch)
  - 10 = R-type
  - 11 = I-type arithmetic
- `funct3`  in  3  instruction[14:12].
- `funct7`  in  7  instruction[31:25].
- `valid`  in  1  instruction in decode is live; gates MDU start.
- `flush`  in  1  abort any MDU operation (branch/trap).
- `rs1_val`  in  XLEN  operand A.
- `rs2_val`  in  XLEN  operand B.
- `alu_ctrl`  out  4  ALU control code (combinational).
- `is_mdu`  out  1  current instruction is an M-extension op (combinational).
- `stall`  out  1  hold the pipeline; MDU result not yet available.
- `mdu_done`  out  1  one-cycle strobe; `mdu_result` valid.
- `mdu_result`  out  XLEN  M-extension result.

## Operation
- ALU codes:
  - Unchanged: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, invalid 1111.
  - New: XOR 0011, SLL 0100, SRL 0101, SRA 1000, SLTU 1001.
- R-type (`ALUOp`=10):
  - funct3 000: `funct7[5]` selects SUB, else ADD.
  - funct3 101: `funct7[5]` selects SRA, else SRL.
  - funct3 100/001/011: XOR/SLL/SLTU.
  - Any `funct7` other than 0000000/0100000/0000001 gives 1111.
- I-type (`ALUOp`=11): same mapping by funct3; funct3 000 is always ADD; funct3 101 uses `funct7[5]` for SRAI/SRLI.
- M-extension: `ALUOp`=10 and `funct7`=0000001 → `is_mdu`=1 and `alu_ctrl`=1111.
  - funct3 000..011: MUL, MULH, MULHSU, MULHU.
  - funct3 100..111: DIV, DIVU, REM, REMU.
- FSM states:
  - IDLE: if `valid & is_mdu`, latch operands and funct3, convert signed operands to magnitudes, go to RUN.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle; 6-bit/7-bit step counter; after XLEN steps go to DONE.
  - DONE: apply sign fix-up and select the low/high half or quotient/remainder; assert `mdu_done`; go to IDLE.
- Divide special cases, detected in IDLE → straight to DONE:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder 0.
- `flush` in RUN or DONE → IDLE next cycle, no `mdu_done`. `rst` has priority over `flush`.
- Operands and opcode change during RUN is ignored; only the values latched at start are used.

## Timing
- `stall` = (IDLE & `valid` & `is_mdu`) | RUN, combinational; low in DONE, so the pipeline advances on the `mdu_done` cycle.
- Start accepted in cycle N → `mdu_done` in cycle N+XLEN+1; special-case divides → N+1.
- `mdu_result` holds its value until the next DONE.
- Back-to-back MDU ops: second starts in the cycle after DONE (IDLE re-samples).
- Reset values: state IDLE, `mdu_done` 0, `mdu_result` 0, counter 0; `stall` 0 when `valid`=0.

## Configuration
- `ALU_CTRL_MDU_DIV_EN`:
  - Defined: full M extension.
  - Undefined: divider datapath removed. DIV/DIVU/REM/REMU give `is_mdu`=0 and `alu_ctrl`=1111 (illegal-instruction path), with no stall. Multiply is unaffected.

## Structure
- Package `alu_pkg`: 4-bit ALU code localparams, `ALUOp` encodings, funct7 constants (0000000/0100000/0000001), FSM state enum, M-op funct3 encodings.
- One sub-module, `mdu_iter`: the FSM, counter and shift-add/restoring datapath. The top level holds decode and `stall` generation.

## Test plan
- R/I decode: `ALUOp`=10, funct3 101, funct7 0100000 → 1000; `ALUOp`=11, funct3 000, funct7 0100000 → 0010; funct7 0000010 → 1111.
- MULH, XLEN=32: 0x80000000 × 0x80000000 → 0x40000000; `mdu_done` exactly 33 cycles after start; `stall` high throughout RUN.
- DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU x/0 → 0xFFFFFFFF at N+1; DIV 0x80000000/−1 → 0x80000000.
- `flush` at cycle 10 of RUN → IDLE next cycle, no `mdu_done`; next MUL 3×5 → 15 normally.
- `rst` asserted mid-RUN → all outputs at reset values next cycle; back-to-back MUL then DIVU both correct, the second starting the cycle after the first DONE.
- With `ALU_CTRL_MDU_DIV_EN` undefined: REMU → `is_mdu`=0, `alu_ctrl` 1111, `stall` 0; MUL still works.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control / MDU encodings for alu_ctrl_mdu.
// Optional divider gated by ALU_CTRL_MDU_DIV_EN.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_BAD  = 4'b1111;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mdu_state_e;

    // alt only turns ADD into SUB for register-register ops
    function automatic logic [3:0] alu_code(
        input logic [2:0] f3,
        input logic       alt,
        input logic       rtype
    );
        logic [3:0] c;
        c = ALU_BAD;
        case (f3)
            3'b000: c = (rtype & alt) ? ALU_SUB : ALU_ADD;
            3'b001: c = ALU_SLL;
            3'b010: c = ALU_SLT;
            3'b011: c = ALU_SLTU;
            3'b100: c = ALU_XOR;
            3'b101: c = alt ? ALU_SRA : ALU_SRL;
            3'b110: c = ALU_OR;
            3'b111: c = ALU_AND;
            default: c = ALU_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// Decode/MDU bundle between control, register file and the ALU.
// Divide ops present only with ALU_CTRL_MDU_DIV_EN.
interface alu_ctrl_mdu_if #(parameter int XLEN = 32);

    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            valid;
    logic            flush;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [3:0]      alu_ctrl;
    logic            is_mdu;
    logic            stall;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    modport master (
        output ALUOp, funct3, funct7, valid, flush, rs1_val, rs2_val,
        input  alu_ctrl, is_mdu, stall, mdu_done, mdu_result
    );

    modport slave (
        input  ALUOp, funct3, funct7, valid, flush, rs1_val, rs2_val,
        output alu_ctrl, is_mdu, stall, mdu_done, mdu_result
    );

endinterface

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Divider datapath built only with ALU_CTRL_MDU_DIV_EN.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_idle,
    output logic            o_run,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam logic [6:0] LAST = 7'(XLEN - 1);

    mdu_state_e      r_state;
    logic [6:0]      r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_q;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_result;
    logic            r_done;

    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_hi_nx;
    logic [XLEN-1:0]   w_lo_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_fix;

`ifdef ALU_CTRL_MDU_DIV_EN
    logic            r_neg_r;
    logic [XLEN:0]   w_shl;
    logic [XLEN+1:0] w_sub;
    logic            w_div0;
    logic            w_ovf;

    assign w_div0 = i_funct3[2] & (i_b == '0);
    assign w_ovf  = i_funct3[2] & ~i_funct3[0]
                  & (i_a == {1'b1, {(XLEN-1){1'b0}}})
                  & (i_b == '1);
`endif

    assign w_sa = i_a[XLEN-1] & ((i_funct3 == F3_MULH)
                              | (i_funct3 == F3_MULHSU)
                              | (i_funct3 == F3_DIV)
                              | (i_funct3 == F3_REM));
    assign w_sb = i_b[XLEN-1] & ((i_funct3 == F3_MULH)
                              | (i_funct3 == F3_DIV)
                              | (i_funct3 == F3_REM));
    assign w_mag_a = w_sa ? -i_a : i_a;
    assign w_mag_b = w_sb ? -i_b : i_b;

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_hi_nx = w_sum[XLEN:1];
        w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
`ifdef ALU_CTRL_MDU_DIV_EN
        w_shl = {r_hi, r_lo[XLEN-1]};
        w_sub = {1'b0, w_shl} - {2'b00, r_a};
        if (r_op[2]) begin
            w_hi_nx = w_sub[XLEN+1] ? w_shl[XLEN-1:0] : w_sub[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], ~w_sub[XLEN+1]};
        end
`endif
    end

    always_comb begin
        w_prod = {w_hi_nx, w_lo_nx};
        if (r_neg_q)
            w_prod = -w_prod;
        w_fix = '0;
        case (r_op)
            F3_MUL:                       w_fix = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
`ifdef ALU_CTRL_MDU_DIV_EN
            F3_DIV, F3_DIVU: w_fix = r_neg_q ? -w_lo_nx : w_lo_nx;
            default:         w_fix = r_neg_r ? -w_hi_nx : w_hi_nx;
`else
            default:         w_fix = '0;
`endif
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
`ifdef ALU_CTRL_MDU_DIV_EN
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: if (i_start) begin
                    r_op    <= i_funct3;
                    r_cnt   <= '0;
                    r_neg_q <= w_sa ^ w_sb;
                    r_a     <= w_mag_a;
                    r_lo    <= w_mag_b;
                    r_hi    <= '0;
                    r_state <= S_RUN;
`ifdef ALU_CTRL_MDU_DIV_EN
                    r_neg_r <= w_sa;
                    if (i_funct3[2]) begin
                        r_a  <= w_mag_b;
                        r_lo <= w_mag_a;
                    end
                    // corner cases skip the iteration entirely
                    if (w_div0) begin
                        r_result <= i_funct3[1] ? i_a : '1;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_ovf) begin
                        r_result <= i_funct3[1] ? '0 : i_a;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
`endif
                end
                S_RUN: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_hi_nx;
                        r_lo  <= w_lo_nx;
                        r_cnt <= r_cnt + 7'd1;
                        if (r_cnt == LAST) begin
                            r_result <= w_fix;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_idle   = (r_state == S_IDLE);
    assign o_run    = (r_state == S_RUN);
    assign o_done   = r_done & ~i_flush;
    assign o_result = r_result;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with iterative M-extension unit and pipeline stall.
// Define ALU_CTRL_MDU_DIV_EN to include DIV/DIVU/REM/REMU.
module alu_ctrl_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    alu_ctrl_mdu_if.slave bus
);

    logic [3:0] w_ctrl;
    logic       w_mdu;
    logic       w_idle;
    logic       w_run;

    always_comb begin
        w_ctrl = ALU_BAD;
        w_mdu  = 1'b0;
        unique case (bus.ALUOp)
            OP_ADD: w_ctrl = ALU_ADD;
            OP_SUB: w_ctrl = ALU_SUB;
            OP_R: begin
                if (bus.funct7 == F7_MDU) begin
`ifdef ALU_CTRL_MDU_DIV_EN
                    w_mdu = 1'b1;
`else
                    w_mdu = ~bus.funct3[2];
`endif
                end else if ((bus.funct7 == F7_BASE) ||
                             (bus.funct7 == F7_ALT)) begin
                    w_ctrl = alu_code(bus.funct3, bus.funct7[5], 1'b1);
                end
            end
            OP_I: w_ctrl = alu_code(bus.funct3, bus.funct7[5], 1'b0);
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (bus.valid & w_mdu),
        .i_flush  (bus.flush),
        .i_funct3 (bus.funct3),
        .i_a      (bus.rs1_val),
        .i_b      (bus.rs2_val),
        .o_idle   (w_idle),
        .o_run    (w_run),
        .o_done   (bus.mdu_done),
        .o_result (bus.mdu_result)
    );

    assign bus.alu_ctrl = w_ctrl;
    assign bus.is_mdu   = w_mdu;
    assign bus.stall    = (w_idle & bus.valid & w_mdu) | w_run;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: decode table, MDU op table, flush/reset/back-to-back.
// Follows ALU_CTRL_MDU_DIV_EN for the divide cases.
module tb_alu_ctrl_mdu;

`ifdef ALU_CTRL_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb_q[$];

    alu_ctrl_mdu_if #(.XLEN(32)) bus ();

    alu_ctrl_mdu #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] ctrl;
        logic       mdu;
    } dec_vec_t;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } mdu_vec_t;

    dec_vec_t dv[$];
    mdu_vec_t mv[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_mdu(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b);
        bus.ALUOp   = 2'b10;
        bus.funct7  = 7'b0000001;
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.valid   = 1'b1;
    endtask

    // called just after the start edge; returns at the done negedge
    task automatic wait_done(input string name, input int lat);
        int   kd;
        logic bad;
        logic [31:0] exp;
        kd  = 0;
        bad = 1'b0;
        for (int k = 1; k <= lat + 4; k++) begin
            @(negedge clk);
            if (bus.mdu_done) begin
                kd = k;
                break;
            end
            if (!bus.stall) bad = 1'b1;
        end
        chk({name, "_latency"}, kd, lat);
        chk({name, "_stall_run"}, bad, 0);
        chk({name, "_stall_done"}, bus.stall, 0);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        chk({name, "_result"}, bus.mdu_result, exp);
    endtask

    task automatic run_op(input mdu_vec_t v);
        drive_mdu(v.f3, v.a, v.b);
        #1;
        chk({v.name, "_stall_start"}, bus.stall, 1);
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        bus.valid   = 1'b0;
        bus.funct3  = 3'($urandom);
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        wait_done(v.name, v.lat);
        @(negedge clk);
    endtask

    task automatic no_done_for(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.mdu_done) seen = 1'b1;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        mdu_vec_t v;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;

        bus.ALUOp = 2'b00; bus.funct3 = 3'b000; bus.funct7 = 7'b0;
        bus.valid = 1'b0;  bus.flush = 1'b0;
        bus.rs1_val = '0;  bus.rs2_val = '0;

        dv.push_back('{2'b10, 3'b101, 7'b0100000, 4'b1000, 1'b0});
        dv.push_back('{2'b11, 3'b000, 7'b0100000, 4'b0010, 1'b0});
        dv.push_back('{2'b10, 3'b000, 7'b0000010, 4'b1111, 1'b0});
        dv.push_back('{2'b00, 3'b111, 7'b0000001, 4'b0010, 1'b0});
        dv.push_back('{2'b01, 3'b010, 7'b0100000, 4'b0110, 1'b0});
        dv.push_back('{2'b10, 3'b000, 7'b0100000, 4'b0110, 1'b0});
        dv.push_back('{2'b10, 3'b000, 7'b0000000, 4'b0010, 1'b0});
        dv.push_back('{2'b10, 3'b111, 7'b0000000, 4'b0000, 1'b0});
        dv.push_back('{2'b10, 3'b110, 7'b0000000, 4'b0001, 1'b0});
        dv.push_back('{2'b10, 3'b010, 7'b0000000, 4'b0111, 1'b0});
        dv.push_back('{2'b10, 3'b011, 7'b0000000, 4'b1001, 1'b0});
        dv.push_back('{2'b10, 3'b100, 7'b0000000, 4'b0011, 1'b0});
        dv.push_back('{2'b10, 3'b001, 7'b0000000, 4'b0100, 1'b0});
        dv.push_back('{2'b10, 3'b101, 7'b0000000, 4'b0101, 1'b0});
        dv.push_back('{2'b11, 3'b101, 7'b0000000, 4'b0101, 1'b0});
        dv.push_back('{2'b11, 3'b101, 7'b0100000, 4'b1000, 1'b0});
        dv.push_back('{2'b11, 3'b000, 7'b0000001, 4'b0010, 1'b0});
        dv.push_back('{2'b10, 3'b000, 7'b0000001, 4'b1111, 1'b1});
        dv.push_back('{2'b10, 3'b011, 7'b0000001, 4'b1111, 1'b1});
        dv.push_back('{2'b10, 3'b100, 7'b0000001, 4'b1111, DIV_EN});
        dv.push_back('{2'b10, 3'b111, 7'b0000001, 4'b1111, DIV_EN});

        mv.push_back('{"mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000,
                       32'h4000_0000, 33});
        mv.push_back('{"mul_3x5", 3'b000, 32'd3, 32'd5, 32'd15, 33});
        mv.push_back('{"mul_neg", 3'b000, 32'hFFFF_FFFF, 32'd2,
                       32'hFFFF_FFFE, 33});
        mv.push_back('{"mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       32'hFFFF_FFFE, 33});
        mv.push_back('{"mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       32'h0, 33});
        mv.push_back('{"mulh_m2x3", 3'b001, 32'hFFFF_FFFE, 32'd3,
                       32'hFFFF_FFFF, 33});
        mv.push_back('{"mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       32'hFFFF_FFFF, 33});
`ifdef ALU_CTRL_MDU_DIV_EN
        mv.push_back('{"div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2,
                       32'hFFFF_FFFD, 33});
        mv.push_back('{"rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2,
                       32'hFFFF_FFFF, 33});
        mv.push_back('{"divu_by0", 3'b101, 32'd1234, 32'd0,
                       32'hFFFF_FFFF, 1});
        mv.push_back('{"div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
                       32'h8000_0000, 1});
        mv.push_back('{"rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
                       32'h0, 1});
        mv.push_back('{"rem_by0", 3'b110, 32'hFFFF_FFF9, 32'd0,
                       32'hFFFF_FFF9, 1});
        mv.push_back('{"remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33});
        mv.push_back('{"divu_big", 3'b101, 32'hFFFF_FFFF, 32'd16,
                       32'h0FFF_FFFF, 33});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", bus.mdu_done, 0);
        chk("rst_result", bus.mdu_result, 0);
        chk("rst_stall", bus.stall, 0);
        rst = 1'b0;

        foreach (dv[i]) begin
            bus.ALUOp  = dv[i].op;
            bus.funct3 = dv[i].f3;
            bus.funct7 = dv[i].f7;
            #1;
            chk($sformatf("dec%0d_ctrl", i), bus.alu_ctrl, dv[i].ctrl);
            chk($sformatf("dec%0d_mdu", i), bus.is_mdu, dv[i].mdu);
            @(negedge clk);
        end

        foreach (mv[i]) run_op(mv[i]);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i[0]) begin
                p = {32'b0, a} * {32'b0, b};
                v = '{$sformatf("rnd_mulhu%0d", i), 3'b011, a, b,
                      p[63:32], 33};
            end else begin
                p = {32'b0, a} * {32'b0, b};
                v = '{$sformatf("rnd_mul%0d", i), 3'b000, a, b,
                      p[31:0], 33};
            end
            run_op(v);
        end

        // flush during RUN
        drive_mdu(3'b000, 32'd100, 32'd100);
        sb_q.push_back(32'd10000);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("flush_idle_stall", bus.stall, 0);
        no_done_for("flush_no_done", 40);
        run_op('{"mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 33});

        // reset mid-RUN
        drive_mdu(3'b000, 32'd9, 32'd9);
        sb_q.push_back(32'd81);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_done", bus.mdu_done, 0);
        chk("midrst_result", bus.mdu_result, 0);
        chk("midrst_stall", bus.stall, 0);
        rst = 1'b0;
        bus.flush = 1'b0;
        sb_q.delete();
        no_done_for("midrst_no_done", 40);

        // back-to-back: second op starts the cycle after DONE
        drive_mdu(3'b000, 32'd6, 32'd7);
        sb_q.push_back(32'd42);
        @(posedge clk);
        #1;
        wait_done("b2b_first", 33);
`ifdef ALU_CTRL_MDU_DIV_EN
        drive_mdu(3'b101, 32'd100, 32'd7);
        sb_q.push_back(32'd14);
`else
        drive_mdu(3'b011, 32'h0001_0000, 32'h0003_0000);
        sb_q.push_back(32'd3);
`endif
        @(negedge clk);
        chk("b2b_restart_stall", bus.stall, 1);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        wait_done("b2b_second", 33);
        @(negedge clk);

`ifndef ALU_CTRL_MDU_DIV_EN
        drive_mdu(3'b111, 32'd100, 32'd7);
        #1;
        chk("nodiv_remu_mdu", bus.is_mdu, 0);
        chk("nodiv_remu_ctrl", bus.alu_ctrl, 4'b1111);
        chk("nodiv_remu_stall", bus.stall, 0);
        @(negedge clk);
        chk("nodiv_remu_stall2", bus.stall, 0);
        no_done_for("nodiv_remu_no_done", 5);
        bus.valid = 1'b0;
        run_op('{"nodiv_mul", 3'b000, 32'd11, 32'd13, 32'd143, 33});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
